// File: rtl/timer_controller_if.sv
// Control/status bundle between user logic and the tick timer.
// The master drives commands; the timer (slave) returns tick and status.
interface timer_controller_if #(
  parameter int CNT_W = 8
);
  logic             load;
  logic [CNT_W-1:0] load_value;
  logic             periodic;
  logic             start;
  logic             pause;
  logic             stop;
  logic             tick;
  logic [CNT_W-1:0] count;
  logic             expired;
  logic             busy;
  logic [1:0]       state;

  modport master (
    output load, load_value, periodic,
    output start, pause, stop,
    input  tick, count, expired, busy, state
  );

  modport slave (
    input  load, load_value, periodic,
    input  start, pause, stop,
    output tick, count, expired, busy, state
  );
endinterface

// File: rtl/timer_controller.sv
// Prescaled tick generator with a loadable down-counter.
// Supports one-shot and periodic expiry plus pause/resume.
module timer_controller #(
  parameter int INPUT_FREQ = 50000000,
  parameter int TICK_FREQ  = 1,
  parameter int CNT_W      = 8
) (
  input logic           clk_in,
  input logic           reset,
  timer_controller_if.slave bus
);
  localparam int PRESCALE = INPUT_FREQ / TICK_FREQ;
  localparam int PW = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PRE_MAX = PW'(PRESCALE - 1);
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] reload_q, reload_d;
  logic [PW-1:0]    pre_q, pre_d;
  logic             expired_q, expired_d;
  logic             tick;

  assign tick = (state_q == RUN) && (pre_q == PRE_MAX)
             && !bus.pause && !bus.stop;

  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      count_q   <= '0;
      reload_q  <= '0;
      pre_q     <= '0;
      expired_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      reload_q  <= reload_d;
      pre_q     <= pre_d;
      expired_q <= expired_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    reload_d  = reload_q;
    pre_d     = pre_q;
    expired_d = 1'b0;
    if (bus.stop) begin
      state_d = IDLE;
      count_d = reload_q;
      pre_d   = '0;
    end else begin
      unique case (state_q)
        IDLE, DONE: begin
          if (bus.load) begin
            reload_d = bus.load_value;
            count_d  = bus.load_value;
          end else if (bus.start) begin
            if (count_q != '0) begin
              state_d = RUN;
              pre_d   = '0;
            end else if (reload_q != '0) begin
              state_d = RUN;
              count_d = reload_q;
              pre_d   = '0;
            end
          end
        end
        RUN: begin
          if (bus.pause) begin
            state_d = PAUSE;
          end else begin
            pre_d = (pre_q == PRE_MAX) ? '0 : pre_q + 1'b1;
            // count of 0 in RUN is unreachable; hold rather than wrap
            if (tick) begin
              if (count_q > ONE) begin
                count_d = count_q - ONE;
              end else if (count_q == ONE) begin
                expired_d = 1'b1;
                if (bus.periodic) begin
                  count_d = reload_q;
                end else begin
                  count_d = '0;
                  state_d = DONE;
                end
              end
            end
          end
        end
        PAUSE: begin
          if (bus.start) state_d = RUN;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign bus.tick    = tick;
  assign bus.count   = count_q;
  assign bus.expired = expired_q;
  assign bus.busy    = (state_q == RUN) || (state_q == PAUSE);
  assign bus.state   = state_q;
endmodule

// File: tb/tb_timer_controller.sv
// Directed and random bench for timer_controller, PRESCALE=4, CNT_W=4.
// Expected values come from a behavioural model of the timer rules.
module tb_timer_controller;
  localparam int P = 4;
  localparam int W = 4;

  logic clk_in = 1'b0;
  logic reset  = 1'b0;
  always #5 clk_in = ~clk_in;

  timer_controller_if #(.CNT_W(W)) bus ();

  timer_controller #(
    .INPUT_FREQ(8),
    .TICK_FREQ (2),
    .CNT_W     (W)
  ) dut (
    .clk_in(clk_in),
    .reset (reset),
    .bus   (bus.slave)
  );

  int errors = 0;
  int checks = 0;

  // model: 0 idle, 1 run, 2 pause, 3 done
  int m_st, m_cnt, m_rel, m_el;
  bit m_exp;
  bit per;
  int cyc;
  int tick_q[$];
  int exp_q[$];
  int want[$];

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  task automatic cmpq(string tag, int got[$], int w[$]);
    chk({tag, "_len"}, got.size(), w.size());
    for (int i = 0; i < got.size() && i < w.size(); i++)
      chk(tag, got[i], w[i]);
  endtask

  function automatic bit m_tick(bit pa, bit sp);
    return m_st == 1 && (m_el % P) == P - 1 && !pa && !sp;
  endfunction

  task automatic m_reset();
    m_st = 0; m_cnt = 0; m_rel = 0; m_el = 0; m_exp = 0;
  endtask

  task automatic m_step(bit ld, int lv, bit st, bit pa, bit sp);
    bit tk;
    m_exp = 0;
    if (sp) begin
      m_st = 0; m_cnt = m_rel; m_el = 0;
    end else if (m_st == 0 || m_st == 3) begin
      if (ld) begin
        m_rel = lv; m_cnt = lv;
      end else if (st && m_cnt != 0) begin
        m_st = 1; m_el = 0;
      end else if (st && m_rel != 0) begin
        m_st = 1; m_cnt = m_rel; m_el = 0;
      end
    end else if (m_st == 1) begin
      if (pa) m_st = 2;
      else begin
        tk = (m_el % P) == P - 1;
        m_el++;
        if (tk && m_cnt > 1) m_cnt--;
        else if (tk && m_cnt == 1) begin
          m_exp = 1;
          if (per) m_cnt = m_rel;
          else begin m_cnt = 0; m_st = 3; end
        end
      end
    end else if (st) begin
      m_st = 1;
    end
  endtask

  task automatic check_outs();
    chk("state",   bus.state,   m_st);
    chk("count",   bus.count,   m_cnt);
    chk("expired", bus.expired, m_exp);
    chk("busy",    bus.busy,    (m_st == 1 || m_st == 2));
  endtask

  // called 1 time unit after a rising edge
  task automatic drive(bit ld, int lv, bit st, bit pa, bit sp);
    bus.load       = ld;
    bus.load_value = W'(lv);
    bus.periodic   = per;
    bus.start      = st;
    bus.pause      = pa;
    bus.stop       = sp;
    #1;
    chk("tick", bus.tick, m_tick(pa, sp));
    if (bus.tick) tick_q.push_back(cyc);
    @(posedge clk_in);
    m_step(ld, lv, st, pa, sp);
    cyc++;
    #1;
    check_outs();
    if (bus.expired) exp_q.push_back(cyc);
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0);
  endtask

  task automatic begin_run();
    tick_q.delete();
    exp_q.delete();
    cyc = 0;
    drive(0, 0, 1, 0, 0);
  endtask

  initial begin
    bus.load = 0; bus.load_value = '0; bus.periodic = 0;
    bus.start = 0; bus.pause = 0; bus.stop = 0;
    per = 0;
    cyc = 0;
    m_reset();
    #2;
    check_outs();
    chk("rst_tick", bus.tick, 0);
    @(posedge clk_in);
    #1;
    reset = 1'b1;

    // one-shot, N=3
    drive(1, 3, 0, 0, 0);
    begin_run();
    idle(14);
    want = {4, 8, 12};
    cmpq("os_ticks", tick_q, want);
    want = {13};
    cmpq("os_exp", exp_q, want);
    chk("os_done", bus.state, 3);

    // start from DONE reloads; periodic
    per = 1;
    begin_run();
    idle(38);
    want = {13, 25, 37};
    cmpq("per_exp", exp_q, want);
    drive(0, 0, 0, 0, 1);
    chk("per_stop", bus.count, 3);

    // pause in cycle 6 for 5 cycles
    per = 0;
    begin_run();
    idle(5);
    drive(0, 0, 0, 1, 0);
    idle(3);
    drive(0, 0, 1, 0, 0);
    idle(9);
    want = {4, 13, 17};
    cmpq("pa_ticks", tick_q, want);
    want = {18};
    cmpq("pa_exp", exp_q, want);

    // stop on second tick
    drive(1, 3, 0, 0, 0);
    begin_run();
    idle(7);
    drive(0, 0, 0, 0, 1);
    idle(6);
    want = {4};
    cmpq("sp_ticks", tick_q, want);
    want = {};
    cmpq("sp_exp", exp_q, want);
    chk("sp_count", bus.count, 3);

    // load 0 then start is ignored
    drive(1, 0, 0, 0, 0);
    drive(0, 0, 1, 0, 0);
    chk("z_idle", bus.state, 0);

    // load during RUN is ignored
    drive(1, 2, 0, 0, 0);
    begin_run();
    idle(2);
    drive(1, 5, 0, 0, 0);
    idle(8);
    drive(0, 0, 1, 0, 0);
    chk("ld_run", bus.count, 2);

    // random commands
    for (int i = 0; i < 400; i++) begin
      per = ($urandom_range(0, 3) != 0);
      drive($urandom_range(0, 9) == 0, $urandom_range(0, 15),
            $urandom_range(0, 5) == 0, $urandom_range(0, 9) == 0,
            $urandom_range(0, 39) == 0);
    end

    // asynchronous reset between edges while running
    per = 0;
    drive(1, 9, 0, 0, 0);
    begin_run();
    idle(3);
    #2;
    reset = 1'b0;
    m_reset();
    #1;
    check_outs();
    chk("ar_tick", bus.tick, 0);
    @(posedge clk_in);
    #1;
    reset = 1'b1;
    for (int i = 0; i < 100; i++) begin
      per = $urandom_range(0, 1);
      drive($urandom_range(0, 7) == 0, $urandom_range(0, 15),
            $urandom_range(0, 4) == 0, $urandom_range(0, 9) == 0,
            $urandom_range(0, 49) == 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
